// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// buffers {PC, instruction, misaligned} entries toward decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        Fetch_En,
  output logic [31:0] IMEM_Address,
  input  logic [31:0] IMEM_Instruction,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Out_Valid,
  input  logic        Out_Ready,
  output logic [31:0] Out_Instruction,
  output logic [31:0] Out_PC,
  output logic        Out_Misaligned
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FAULT = 1'b1;

  logic [31:0]   pc_q, pc_d;
  logic [0:0]    state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
  logic        mis_mem  [DEPTH];

  logic        pop, push, pc_misaligned;
  logic [31:0] wr_inst;

  assign IMEM_Address  = pc_q;
  assign pc_misaligned = |pc_q[1:0];

  assign Out_Valid = (count_q != '0);
  assign pop       = Out_Valid & Out_Ready;
  assign push      = (state_q == ST_RUN) & Fetch_En & ~Redirect &
                     ((count_q < DEPTH_C) | pop);
  assign wr_inst   = pc_misaligned ? NOP_INST : IMEM_Instruction;

  // Storage is not reset, so the head is gated to zero whenever the buffer is empty.
  assign Out_PC          = Out_Valid ? pc_mem[rd_ptr_q]   : '0;
  assign Out_Instruction = Out_Valid ? inst_mem[rd_ptr_q] : '0;
  assign Out_Misaligned  = Out_Valid & mis_mem[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pc_d     = pc_q;
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (Redirect) begin
      // The old head may still be popped this cycle; decode kills it downstream.
      pc_d     = Redirect_PC;
      state_d  = ST_RUN;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (pc_misaligned) begin
          state_d = ST_FAULT;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_RUN;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the buffer array has no reset; validity is tracked solely by count_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= wr_inst;
      mis_mem[wr_ptr_q]  <= pc_misaligned;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, backpressure, redirect, misalignment,
// address wrap, Fetch_En hold and asynchronous reset.
module tb_fetch_unit;

  logic        CLK;
  logic        RSTN;
  logic        Fetch_En;
  logic [31:0] IMEM_Address;
  logic [31:0] IMEM_Instruction;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [31:0] Out_Instruction;
  logic [31:0] Out_PC;
  logic        Out_Misaligned;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .Fetch_En         (Fetch_En),
    .IMEM_Address     (IMEM_Address),
    .IMEM_Instruction (IMEM_Instruction),
    .Redirect         (Redirect),
    .Redirect_PC      (Redirect_PC),
    .Out_Valid        (Out_Valid),
    .Out_Ready        (Out_Ready),
    .Out_Instruction  (Out_Instruction),
    .Out_PC           (Out_PC),
    .Out_Misaligned   (Out_Misaligned)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory: two fixed words, every other address returns 0x1000_0000 | addr.
  always_comb begin
    case (IMEM_Address)
      32'h0000_0000: IMEM_Instruction = 32'h0000_7337;
      32'h0000_0004: IMEM_Instruction = 32'h003e_83b7;
      default:       IMEM_Instruction = 32'h1000_0000 | IMEM_Address;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic mis);
    check({tag, " valid"}, 32'(Out_Valid), 32'd1);
    check({tag, " pc"}, Out_PC, pc);
    check({tag, " inst"}, Out_Instruction, inst);
    check({tag, " mis"}, 32'(Out_Misaligned), 32'(mis));
  endtask

  initial begin
    RSTN        = 1'b0;
    Fetch_En    = 1'b1;
    Out_Ready   = 1'b1;
    Redirect    = 1'b0;
    Redirect_PC = '0;

    // Reset state
    step();
    check("rst valid", 32'(Out_Valid), 32'd0);
    check("rst pc", Out_PC, 32'd0);
    check("rst inst", Out_Instruction, 32'd0);
    check("rst mis", 32'(Out_Misaligned), 32'd0);
    check("rst addr", IMEM_Address, 32'd0);
    RSTN = 1'b1;

    // Sequential fetch, 1 per cycle
    step();
    check_head("seq0", 32'h0, 32'h0000_7337, 1'b0);
    check("seq0 addr", IMEM_Address, 32'h4);
    step();
    check_head("seq1", 32'h4, 32'h003e_83b7, 1'b0);
    check("seq1 addr", IMEM_Address, 32'h8);
    step();
    check_head("seq2", 32'h8, 32'h1000_0008, 1'b0);

    // Restart at 0 with decode stalled
    Redirect = 1'b1; Redirect_PC = 32'h0; Out_Ready = 1'b0;
    step();
    Redirect = 1'b0;
    check("bp flush valid", 32'(Out_Valid), 32'd0);
    check("bp flush addr", IMEM_Address, 32'h0);
    for (int i = 0; i < 4; i++) step();
    check_head("bp hold", 32'h0, 32'h0000_7337, 1'b0);
    check("bp stall addr", IMEM_Address, 32'h8);
    Out_Ready = 1'b1;
    step();
    check_head("bp rel1", 32'h4, 32'h003e_83b7, 1'b0);
    check("bp rel1 addr", IMEM_Address, 32'hC);
    step();
    check_head("bp rel2", 32'h8, 32'h1000_0008, 1'b0);

    // Redirect while buffer holds 8 and 12
    Redirect = 1'b1; Redirect_PC = 32'h48;
    step();
    Redirect = 1'b0;
    check("rd flush valid", 32'(Out_Valid), 32'd0);
    check("rd addr", IMEM_Address, 32'h48);
    step();
    check_head("rd first", 32'h48, 32'h1000_0048, 1'b0);
    step();
    check_head("rd second", 32'h4C, 32'h1000_004C, 1'b0);

    // Misaligned redirect enters FAULT
    Redirect = 1'b1; Redirect_PC = 32'h6;
    step();
    Redirect = 1'b0;
    check("mis flush valid", 32'(Out_Valid), 32'd0);
    step();
    check_head("mis entry", 32'h6, 32'h0000_0013, 1'b1);
    check("mis addr", IMEM_Address, 32'h6);
    step();
    check("fault valid", 32'(Out_Valid), 32'd0);
    step();
    check("fault valid2", 32'(Out_Valid), 32'd0);
    check("fault addr", IMEM_Address, 32'h6);

    // Recover from FAULT
    Redirect = 1'b1; Redirect_PC = 32'h10;
    step();
    Redirect = 1'b0;
    check("rec addr", IMEM_Address, 32'h10);
    step();
    check_head("rec entry", 32'h10, 32'h1000_0010, 1'b0);

    // Address wrap
    Redirect = 1'b1; Redirect_PC = 32'hFFFF_FFFC;
    step();
    Redirect = 1'b0;
    step();
    check_head("wrap top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0);
    check("wrap addr", IMEM_Address, 32'h0);
    step();
    check_head("wrap zero", 32'h0, 32'h0000_7337, 1'b0);

    // Fetch_En low: buffer drains, PC held
    Fetch_En = 1'b0;
    step();
    check("fen valid", 32'(Out_Valid), 32'd0);
    check("fen addr", IMEM_Address, 32'h4);
    Fetch_En = 1'b1;
    step();
    check_head("fen resume", 32'h4, 32'h003e_83b7, 1'b0);

    // Fill two entries, then async reset mid-cycle
    Out_Ready = 1'b0;
    step();
    check_head("ar full", 32'h4, 32'h003e_83b7, 1'b0);
    check("ar full addr", IMEM_Address, 32'hC);
    #2;
    RSTN = 1'b0;
    #1;
    check("ar valid", 32'(Out_Valid), 32'd0);
    check("ar addr", IMEM_Address, 32'h0);
    check("ar pc", Out_PC, 32'h0);
    RSTN = 1'b1;
    Out_Ready = 1'b1;
    step();
    check_head("ar restart", 32'h0, 32'h0000_7337, 1'b0);
    check("ar restart addr", IMEM_Address, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
